fnd_scan_decoder: RTL and testbench

FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

---
 rtl/fnd_scan_pkg.sv | 40 ++++
 rtl/fnd_glyph_dec.sv | 40 ++++
 rtl/fnd_scan_decoder.sv | 248 ++++++++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_scan_pkg.sv
// Shared definitions for the FND scan decoder: active-low font constants,
// decoded code values, FSM state encoding and small digit-select helpers.
package fnd_scan_pkg;

  // Active-low 7-segment fonts {dp,g,f,e,d,c,b,a} with dp forced off (1)
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  // Decoded codes for a dark digit and an unrecognised pattern
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } fnd_state_e;

  // True when exactly one digit-select line is driven low
  function automatic logic comm_is_sel(input logic [3:0] comm);
    return ($countones(~comm) == 1);
  endfunction

  // Active-high slot mask for an active-low one-hot digit select
  function automatic logic [3:0] comm_to_mask(input logic [3:0] comm);
    return ~comm;
  endfunction

endpackage

// File: rtl/fnd_glyph_dec.sv
// Combinational 7-segment font decoder. The dp bit is ignored; the segment
// pattern maps to a digit code, CODE_BLANK for a dark digit or CODE_ERR
// (with o_err raised) for anything unrecognised.
module fnd_glyph_dec
  import fnd_scan_pkg::*;
(
  input  logic [7:0] i_font,
  output logic [3:0] o_code,
  output logic       o_err
);

  logic [7:0] w_seg;

  // Force dp off so the lookup only sees the seven segments
  assign w_seg = {1'b1, i_font[6:0]};

  // Map the segment pattern to its digit code
  always_comb begin
    o_code = CODE_ERR;
    o_err  = 1'b0;
    case (w_seg)
      FONT_0:     o_code = 4'd0;
      FONT_1:     o_code = 4'd1;
      FONT_2:     o_code = 4'd2;
      FONT_3:     o_code = 4'd3;
      FONT_4:     o_code = 4'd4;
      FONT_5:     o_code = 4'd5;
      FONT_6:     o_code = 4'd6;
      FONT_7:     o_code = 4'd7;
      FONT_8:     o_code = 4'd8;
      FONT_9:     o_code = 4'd9;
      FONT_BLANK: o_code = CODE_BLANK;
      default: begin
        o_code = CODE_ERR;
        o_err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// FND scan decoder: watches a multiplexed 4-digit 7-segment drive
// (fnd_comm / fnd_font), samples each digit once its inputs have settled,
// and publishes a complete 4-digit frame once every position was seen.
// Optional macro FND_SCAN_STALL_EN adds a stall detector on fnd_comm.
//
// Output protocol: frame_valid is a single-cycle strobe with no ready;
// digit/dp change only on the cycle frame_valid is high and hold otherwise.
module fnd_scan_decoder
  import fnd_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int STALL_CYC  = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  fnd_comm,
  input  logic [7:0]  fnd_font,
  output logic [15:0] digit,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        glyph_err,
  output logic        comm_err,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  localparam int              CW         = $clog2(SETTLE_CYC + 1) + 1;
  localparam logic [CW-1:0]   SETTLE_MAX = CW'(SETTLE_CYC);

  fnd_state_e    r_state;
  fnd_state_e    w_state_nxt;

  logic [3:0]    r_prev_comm;
  logic [7:0]    r_prev_font;
  logic [CW-1:0] r_stable;
  logic [CW-1:0] w_stable_now;

  logic          w_blank;
  logic          w_sel;
  logic          w_bad;
  logic          w_change;
  logic          w_settled;
  logic          w_latch;

  logic [3:0]    w_dec_code;
  logic          w_dec_err;

  logic [3:0]    r_cap_comm;
  logic [3:0]    r_cap_code;
  logic          r_cap_dp;
  logic          r_cap_err;

  logic [15:0]   r_shadow_code;
  logic [3:0]    r_shadow_dp;
  logic [3:0]    r_seen;

  logic [3:0]    w_slot_mask;
  logic [15:0]   w_merged_code;
  logic [3:0]    w_merged_dp;
  logic [3:0]    w_merged_seen;
  logic          w_done;

  logic [15:0]   r_digit;
  logic [3:0]    r_dp;
  logic          r_frame_valid;
  logic          r_glyph_err;
  logic          r_comm_err;

  fnd_glyph_dec u_glyph_dec (
    .i_font (fnd_font),
    .o_code (w_dec_code),
    .o_err  (w_dec_err)
  );

  // Classify the digit select and detect any input change since last cycle
  always_comb begin
    w_blank  = (fnd_comm == 4'hF);
    w_sel    = comm_is_sel(fnd_comm);
    w_bad    = !w_blank && !w_sel;
    w_change = (fnd_comm != r_prev_comm) || (fnd_font != r_prev_font);
  end

  // Count of consecutive cycles (including this one) with unchanged inputs
  always_comb begin
    w_stable_now = r_stable;
    if (w_change)
      w_stable_now = CW'(1);
    else if (r_stable < SETTLE_MAX)
      w_stable_now = r_stable + CW'(1);
    w_settled = w_sel && (w_stable_now >= SETTLE_MAX);
  end

  // Track previous inputs and the stability count; blank/invalid clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_comm <= 4'hF;
      r_prev_font <= 8'hFF;
      r_stable    <= '0;
    end else begin
      r_prev_comm <= fnd_comm;
      r_prev_font <= fnd_font;
      r_stable    <= w_sel ? w_stable_now : '0;
    end
  end

  // Next-state logic of the capture FSM
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel)
          w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!w_sel) begin
          w_state_nxt = ST_IDLE;
        end else if (w_settled) begin
          w_state_nxt = ST_CAPTURE;
          w_latch     = 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!w_sel)
          w_state_nxt = ST_IDLE;
        else if (fnd_comm != r_cap_comm)
          w_state_nxt = ST_SETTLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Freeze the settled sample so CAPTURE is immune to inputs moving on
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_comm <= 4'hF;
      r_cap_code <= CODE_BLANK;
      r_cap_dp   <= 1'b0;
      r_cap_err  <= 1'b0;
    end else if (w_latch) begin
      r_cap_comm <= fnd_comm;
      r_cap_code <= w_dec_code;
      r_cap_dp   <= ~fnd_font[7];
      r_cap_err  <= w_dec_err;
    end
  end

  // Shadow frame with the frozen sample merged into its slot
  always_comb begin
    w_slot_mask   = comm_to_mask(r_cap_comm);
    w_merged_code = r_shadow_code;
    w_merged_dp   = r_shadow_dp;
    for (int i = 0; i < 4; i++) begin
      if (w_slot_mask[i]) begin
        w_merged_code[i*4 +: 4] = r_cap_code;
        w_merged_dp[i]          = r_cap_dp;
      end
    end
    w_merged_seen = r_seen | w_slot_mask;
    w_done        = &w_merged_seen;
  end

  // Write the shadow slot in CAPTURE and publish when all four are seen
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_code <= '0;
      r_shadow_dp   <= '0;
      r_seen        <= '0;
      r_digit       <= 16'hFFFF;
      r_dp          <= 4'h0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (r_state == ST_CAPTURE) begin
        r_shadow_code <= w_merged_code;
        r_shadow_dp   <= w_merged_dp;
        if (w_done) begin
          r_digit       <= w_merged_code;
          r_dp          <= w_merged_dp;
          r_frame_valid <= 1'b1;
          r_seen        <= '0;
        end else begin
          r_seen        <= w_merged_seen;
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_glyph_err <= 1'b0;
      r_comm_err  <= 1'b0;
    end else begin
      if (r_state == ST_CAPTURE && r_cap_err)
        r_glyph_err <= 1'b1;
      if (w_bad)
        r_comm_err <= 1'b1;
    end
  end

`ifdef FND_SCAN_STALL_EN
  localparam int            SW        = $clog2(STALL_CYC + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYC);

  logic [SW-1:0] r_stall_cnt;
  logic          r_stall;

  // Count cycles without a digit-select change; flag once the limit is hit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_stall     <= 1'b0;
    end else if (fnd_comm != r_prev_comm) begin
      r_stall_cnt <= '0;
      r_stall     <= 1'b0;
    end else begin
      if (r_stall_cnt != STALL_MAX)
        r_stall_cnt <= r_stall_cnt + SW'(1);
      if (r_stall_cnt >= STALL_MAX - SW'(1))
        r_stall <= 1'b1;
    end
  end

  assign stall = r_stall;
`else
  assign stall = 1'b0;
`endif

  assign digit       = r_digit;
  assign dp          = r_dp;
  assign frame_valid = r_frame_valid;
  assign glyph_err   = r_glyph_err;
  assign comm_err    = r_comm_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Testbench for fnd_scan_decoder: directed scans plus randomized scan
// sequences, checked against a frame-level reference model.
module tb_fnd_scan_decoder;

  localparam int SETTLE = 4;
  localparam int STALLC = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  fnd_comm = 4'hF;
  logic [7:0]  fnd_font = 8'hFF;
  logic [15:0] digit;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        glyph_err;
  logic        comm_err;
  logic        stall;
  logic [1:0]  dbg_state;

  fnd_scan_decoder #(.SETTLE_CYC(SETTLE), .STALL_CYC(STALLC)) dut (
    .clk         (clk),
    .reset       (reset),
    .fnd_comm    (fnd_comm),
    .fnd_font    (fnd_font),
    .digit       (digit),
    .dp          (dp),
    .frame_valid (frame_valid),
    .glyph_err   (glyph_err),
    .comm_err    (comm_err),
    .stall       (stall),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_frames_exp = 0;
  int n_frames_got = 0;
  int last_pos = -1;

  logic [19:0] exp_q[$];
  logic [3:0]  m_code[4];
  logic        m_dp[4];
  bit          m_seen[4];
  bit          m_glyph;
  bit          m_comm;
  logic [7:0]  font_tab[10];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference decode: look the seven segments up in the font table
  function automatic logic [3:0] ref_code(input logic [7:0] font);
    logic [7:0] seg;
    seg = font | 8'h80;
    for (int i = 0; i < 10; i++)
      if (seg == font_tab[i]) return 4'(i);
    if (seg == 8'hFF) return 4'hF;
    return 4'hE;
  endfunction

  function automatic logic [19:0] model_frame();
    return {m_dp[3], m_dp[2], m_dp[1], m_dp[0],
            m_code[3], m_code[2], m_code[1], m_code[0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_seen[i] = 0;
    m_glyph = 0;
    m_comm  = 0;
  endtask

  // A position that held still long enough lands in its slot
  task automatic model_capture(input int pos, input logic [7:0] font);
    m_code[pos] = ref_code(font);
    m_dp[pos]   = ~font[7];
    if (m_code[pos] == 4'hE) m_glyph = 1;
    m_seen[pos] = 1;
    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
      exp_q.push_back(model_frame());
      n_frames_exp++;
      for (int i = 0; i < 4; i++) m_seen[i] = 0;
    end
  endtask

  // ---------------- frame monitor ----------------
  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      logic [19:0] e;
      n_frames_got++;
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("frame_digit", 32'(digit), 32'(e[15:0]));
        check("frame_dp", 32'(dp), 32'(e[19:16]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge
  task automatic drive_pos(input int pos, input logic [7:0] font, input int dwell);
    fnd_comm = ~(4'b0001 << pos);
    fnd_font = font;
    last_pos = pos;
    for (int i = 1; i <= dwell; i++) begin
      @(posedge clk); #1;
      if (i == SETTLE) model_capture(pos, font);
    end
  endtask

  task automatic drive_raw(input logic [3:0] comm, input logic [7:0] font, input int cycles);
    fnd_comm = comm;
    fnd_font = font;
    if (comm != 4'hF && $countones(~comm) != 1) m_comm = 1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    fnd_comm = 4'hF;
    fnd_font = 8'hFF;
    model_clear();
    last_pos = -1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit", 32'(digit), 32'hFFFF);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_glyph_err", 32'(glyph_err), 32'h0);
    check("rst_comm_err", 32'(comm_err), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic scan4(input logic [7:0] f3, input logic [7:0] f2,
                       input logic [7:0] f1, input logic [7:0] f0, input int dwell);
    drive_pos(3, f3, dwell);
    drive_pos(2, f2, dwell);
    drive_pos(1, f1, dwell);
    drive_pos(0, f0, dwell);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int frames_before;
    font_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    model_clear();

    apply_reset();

    // "1234", two full scans with a 5-cycle dwell
    frames_before = n_frames_got;
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 5);
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 5);
    drive_raw(4'hF, 8'hFF, 6);
    check("scan1234_digit", 32'(digit), 32'h1234);
    check("scan1234_dp", 32'(dp), 32'h0);
    check("scan1234_frames", 32'(n_frames_got - frames_before), 32'd2);
    check("scan1234_glyph_err", 32'(glyph_err), 32'h0);
    check("scan1234_comm_err", 32'(comm_err), 32'h0);

    // Position 2 shows 8 with its decimal point lit
    scan4(8'hC0, 8'h00, 8'hC0, 8'hC0, 5);
    drive_raw(4'hF, 8'hFF, 6);
    check("dp8_slot2", 32'(digit[11:8]), 32'h8);
    check("dp8_dp", 32'(dp), 32'b0100);

    // 3-cycle dwell never settles: no frame
    frames_before = n_frames_got;
    scan4(8'hF9, 8'hF9, 8'hF9, 8'hF9, 3);
    drive_raw(4'hF, 8'hFF, 6);
    check("short_dwell_frames", 32'(n_frames_got - frames_before), 32'd0);

    // Two lines low at once: comm error, no capture
    drive_raw(4'b1100, 8'h92, 6);
    drive_raw(4'hF, 8'hFF, 3);
    check("bad_comm_err", 32'(comm_err), 32'h1);
    check("bad_comm_frames", 32'(n_frames_got - frames_before), 32'd0);

    // Reset after three captured positions, then "5678"
    drive_pos(3, 8'h90, 5);
    drive_pos(2, 8'h90, 5);
    drive_pos(1, 8'h90, 5);
    drive_raw(4'hF, 8'hFF, 2);
    apply_reset();
    frames_before = n_frames_got;
    scan4(8'h92, 8'h82, 8'hF8, 8'h80, 5);
    drive_raw(4'hF, 8'hFF, 6);
    check("after_rst_frames", 32'(n_frames_got - frames_before), 32'd1);
    check("after_rst_digit", 32'(digit), 32'h5678);

    // Unrecognised font on position 1, error persists
    scan4(8'hF9, 8'hF9, 8'h55, 8'hF9, 5);
    drive_raw(4'hF, 8'hFF, 100);
    check("glyph_slot1", 32'(digit[7:4]), 32'hE);
    check("glyph_err_sticky", 32'(glyph_err), 32'h1);

    // Randomized scan traffic
    apply_reset();
    for (int n = 0; n < 120; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        drive_raw(4'hF, 8'($urandom), $urandom_range(2, 4));
      end else if (kind == 1) begin
        logic [3:0] bad_tab[4];
        bad_tab = '{4'b1100, 4'b0000, 4'b1010, 4'b0101};
        drive_raw(bad_tab[$urandom_range(0, 3)], 8'($urandom), $urandom_range(2, 3));
      end else begin
        int pos;
        int k;
        logic [7:0] f;
        pos = $urandom_range(0, 3);
        while (pos == last_pos) pos = $urandom_range(0, 3);
        k = $urandom_range(0, 11);
        if (k < 10)       f = font_tab[k];
        else if (k == 10) f = 8'hFF;
        else              f = 8'($urandom);
        if ($urandom_range(0, 3) == 0) f[7] = 1'b0;
        drive_pos(pos, f, $urandom_range(3, 7));
      end
    end
    drive_raw(4'hF, 8'hFF, 8);
    check("rand_glyph_err", 32'(glyph_err), 32'(m_glyph));
    check("rand_comm_err", 32'(comm_err), 32'(m_comm));

`ifdef FND_SCAN_STALL_EN
    drive_pos(0, 8'hC0, 22);
    check("stall_high", 32'(stall), 32'h1);
    drive_pos(1, 8'hC0, 2);
    check("stall_cleared", 32'(stall), 32'h0);
    drive_raw(4'hF, 8'hFF, 8);
`else
    drive_pos(0, 8'hC0, 30);
    check("stall_tied_off", 32'(stall), 32'h0);
    drive_raw(4'hF, 8'hFF, 8);
`endif

    check("total_frames", 32'(n_frames_got), 32'(n_frames_exp));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
